// File: rtl/calc_port_driver_if.sv
// Calc3 port bundle: command intake, request/response to the unit, completion and status.
// slave = the port driver, master = whoever feeds commands and models the unit.
interface calc_port_driver_if #(
    parameter int NUM_TAGS = 4,
    parameter int DATA_W   = 32
);
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int CNT_W = $clog2(NUM_TAGS + 1);

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cmd;
    logic [3:0]        in_d1;
    logic [3:0]        in_d2;
    logic [3:0]        in_r1;
    logic [DATA_W-1:0] in_data;

    logic [3:0]        req_cmd;
    logic [3:0]        req_d1;
    logic [3:0]        req_d2;
    logic [3:0]        req_r1;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_data;

    logic [1:0]        out_resp;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;

    logic              cpl_valid;
    logic [TAG_W-1:0]  cpl_tag;
    logic [3:0]        cpl_cmd;
    logic [1:0]        cpl_resp;
    logic [DATA_W-1:0] cpl_data;
    logic              cpl_timeout;
    logic              spurious_err;
    logic [CNT_W-1:0]  outstanding;

    modport master (
        output in_valid, in_cmd, in_d1, in_d2, in_r1, in_data,
        input  in_ready,
        input  req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
        output out_resp, out_tag, out_data,
        input  cpl_valid, cpl_tag, cpl_cmd, cpl_resp, cpl_data, cpl_timeout,
        input  spurious_err, outstanding
    );

    modport slave (
        input  in_valid, in_cmd, in_d1, in_d2, in_r1, in_data,
        output in_ready,
        output req_cmd, req_d1, req_d2, req_r1, req_tag, req_data,
        input  out_resp, out_tag, out_data,
        output cpl_valid, cpl_tag, cpl_cmd, cpl_resp, cpl_data, cpl_timeout,
        output spurious_err, outstanding
    );
endinterface

// File: rtl/calc_port_driver.sv
// Calc3 port agent: tag allocation, 1-cycle registered requests and completions, timeout reclaim.
// in_ready drops only when every tag is busy (from the registered mask); completions are never stalled.
module calc_port_driver #(
    parameter int NUM_TAGS = 4,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 64
) (
    input logic             clk,
    input logic             reset,
    calc_port_driver_if.slave bus
);
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int CNT_W = $clog2(NUM_TAGS + 1);
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_EXP = AGE_W'(TIMEOUT - 1);

    logic                rdy_q;
    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [3:0]          cmd_q [NUM_TAGS];
    logic [3:0]          cmd_d [NUM_TAGS];
    logic [AGE_W-1:0]    age_q [NUM_TAGS];
    logic [AGE_W-1:0]    age_d [NUM_TAGS];

    logic [3:0]          req_cmd_q, req_cmd_d, req_d1_q, req_d1_d;
    logic [3:0]          req_d2_q, req_d2_d, req_r1_q, req_r1_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;

    logic                cpl_valid_q, cpl_valid_d, cpl_timeout_q, cpl_timeout_d;
    logic [TAG_W-1:0]    cpl_tag_q, cpl_tag_d;
    logic [3:0]          cpl_cmd_q, cpl_cmd_d;
    logic [1:0]          cpl_resp_q, cpl_resp_d;
    logic [DATA_W-1:0]   cpl_data_q, cpl_data_d;
    logic                spur_q, spur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                any_free, exp_any;
    logic [TAG_W-1:0]    free_tag, exp_tag;
    logic                in_ready, accept, alloc, rsp_vld, rsp_hit;

    // Lowest free tag and lowest expired tag: scan high to low so the lowest index wins.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        exp_any  = 1'b0;
        exp_tag  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                any_free = 1'b1;
                free_tag = TAG_W'(i);
            end
            if (busy_q[i] && age_q[i] >= AGE_EXP) begin
                exp_any = 1'b1;
                exp_tag = TAG_W'(i);
            end
        end
    end

    assign in_ready = rdy_q & any_free;
    assign accept   = bus.in_valid & in_ready;
    assign alloc    = accept & (bus.in_cmd != 4'd0);
    assign rsp_vld  = bus.out_resp != 2'b00;
    assign rsp_hit  = rsp_vld & busy_q[bus.out_tag];

    always_comb begin
        busy_d        = busy_q;
        cmd_d         = cmd_q;
        req_cmd_d     = '0;
        req_d1_d      = '0;
        req_d2_d      = '0;
        req_r1_d      = '0;
        req_tag_d     = '0;
        req_data_d    = '0;
        cpl_valid_d   = 1'b0;
        cpl_timeout_d = 1'b0;
        cpl_tag_d     = '0;
        cpl_cmd_d     = '0;
        cpl_resp_d    = '0;
        cpl_data_d    = '0;
        spur_d        = spur_q | (rsp_vld & ~busy_q[bus.out_tag]);

        // Ages saturate so a losing timeout keeps retrying every cycle.
        for (int i = 0; i < NUM_TAGS; i++) begin
            age_d[i] = age_q[i];
            if (busy_q[i] && age_q[i] != AGE_MAX)
                age_d[i] = age_q[i] + AGE_W'(1);
        end

        if (rsp_hit) begin
            busy_d[bus.out_tag] = 1'b0;
            cpl_valid_d = 1'b1;
            cpl_tag_d   = bus.out_tag;
            cpl_cmd_d   = cmd_q[bus.out_tag];
            cpl_resp_d  = bus.out_resp;
            cpl_data_d  = bus.out_data;
        end else if (exp_any) begin
            busy_d[exp_tag] = 1'b0;
            cpl_valid_d   = 1'b1;
            cpl_timeout_d = 1'b1;
            cpl_tag_d     = exp_tag;
            cpl_cmd_d     = cmd_q[exp_tag];
        end

        // The allocated tag was free in busy_q, so it never collides with the tag freed above.
        if (alloc) begin
            busy_d[free_tag] = 1'b1;
            cmd_d[free_tag]  = bus.in_cmd;
            age_d[free_tag]  = '0;
            req_cmd_d  = bus.in_cmd;
            req_d1_d   = bus.in_d1;
            req_d2_d   = bus.in_d2;
            req_r1_d   = bus.in_r1;
            req_tag_d  = free_tag;
            req_data_d = bus.in_data;
        end

        cnt_d = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q         <= 1'b0;
            busy_q        <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                cmd_q[i] <= '0;
                age_q[i] <= '0;
            end
            req_cmd_q     <= '0;
            req_d1_q      <= '0;
            req_d2_q      <= '0;
            req_r1_q      <= '0;
            req_tag_q     <= '0;
            req_data_q    <= '0;
            cpl_valid_q   <= 1'b0;
            cpl_timeout_q <= 1'b0;
            cpl_tag_q     <= '0;
            cpl_cmd_q     <= '0;
            cpl_resp_q    <= '0;
            cpl_data_q    <= '0;
            spur_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            rdy_q         <= 1'b1;
            busy_q        <= busy_d;
            cmd_q         <= cmd_d;
            age_q         <= age_d;
            req_cmd_q     <= req_cmd_d;
            req_d1_q      <= req_d1_d;
            req_d2_q      <= req_d2_d;
            req_r1_q      <= req_r1_d;
            req_tag_q     <= req_tag_d;
            req_data_q    <= req_data_d;
            cpl_valid_q   <= cpl_valid_d;
            cpl_timeout_q <= cpl_timeout_d;
            cpl_tag_q     <= cpl_tag_d;
            cpl_cmd_q     <= cpl_cmd_d;
            cpl_resp_q    <= cpl_resp_d;
            cpl_data_q    <= cpl_data_d;
            spur_q        <= spur_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.req_cmd      = req_cmd_q;
    assign bus.req_d1       = req_d1_q;
    assign bus.req_d2       = req_d2_q;
    assign bus.req_r1       = req_r1_q;
    assign bus.req_tag      = req_tag_q;
    assign bus.req_data     = req_data_q;
    assign bus.cpl_valid    = cpl_valid_q;
    assign bus.cpl_tag      = cpl_tag_q;
    assign bus.cpl_cmd      = cpl_cmd_q;
    assign bus.cpl_resp     = cpl_resp_q;
    assign bus.cpl_data     = cpl_data_q;
    assign bus.cpl_timeout  = cpl_timeout_q;
    assign bus.spurious_err = spur_q;
    assign bus.outstanding  = cnt_q;
endmodule

// File: doc/calc_port_driver.md
Name: calc_port_driver

Overview:
- Synthesizable request/response agent for one Calc3 port (req4/out4 style), placed directly in front of the arithmetic unit.
- Accepts commands on a valid/ready input and drives them onto the port as single-cycle requests.
- Allocates and recycles the 2-bit tags, matches responses to outstanding tags, and emits one completion record per request.
- Detects timeouts and spurious responses.

Parameters:
- NUM_TAGS, 4, tag pool size; tag width is clog2(NUM_TAGS), which is 2 at the default.
- DATA_W, 32, operand and result width.
- TIMEOUT, 64, cycles a tag may stay outstanding before it is reclaimed.

Ports:
- clk  in  1  port clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted when in_valid and in_ready are both high.
- in_cmd  in  4  Calc3 opcode; 0 is a no-op.
- in_d1  in  4  source register 1.
- in_d2  in  4  source register 2.
- in_r1  in  4  destination register.
- in_data  in  DATA_W  store data.
- req_cmd  out  4  request opcode to the unit.
- req_d1  out  4  request source register 1 to the unit.
- req_d2  out  4  request source register 2 to the unit.
- req_r1  out  4  request destination register to the unit.
- req_tag  out  2  request tag to the unit.
- req_data  out  DATA_W  request store data to the unit.
- out_resp  in  2  unit response; 00 none, 01 ok, 10 overflow/underflow, 11 invalid.
- out_tag  in  2  response tag.
- out_data  in  DATA_W  response data.
- cpl_valid  out  1  one-cycle completion strobe.
- cpl_tag  out  2  completed tag.
- cpl_cmd  out  4  opcode of the completed request.
- cpl_resp  out  2  response code; 00 when the completion is a timeout.
- cpl_data  out  DATA_W  response data; 0 on timeout.
- cpl_timeout  out  1  completion produced by timeout.
- spurious_err  out  1  sticky; set by a response whose tag is not outstanding.
- outstanding  out  3  count of busy tags, 0..NUM_TAGS.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0; in_ready goes to 0.
  - Busy mask, age counters and stored opcodes are cleared.
  - in_ready returns to 1 on the first edge after reset deasserts.
- Per-tag state is a busy bit, a stored cmd, and an age counter of width clog2(TIMEOUT+1).
- in_ready = not-in-reset AND at least one tag free, using the registered busy mask.
- Accept (in_valid & in_ready at posedge):
  - The lowest-numbered free tag is allocated, its busy bit set, cmd stored, age cleared.
  - req_* are registered: they carry the command in the cycle following acceptance.
  - req_* hold for exactly one cycle, then return to all-zero (req_cmd = 0, no-op) unless another accept occurred.
  - Back-to-back accepts produce back-to-back requests with distinct tags.
- No-op input (in_cmd = 0) is accepted but allocates no tag and produces no request or completion.
- Response (out_resp != 00 at posedge):
  - If out_tag is busy: one cycle later cpl_valid=1 with tag, stored cmd, resp, data; the tag's busy bit clears.
  - If out_tag is not busy: spurious_err is set and held until reset; no completion is produced.
- Freed-tag timing: a tag freed by a response becomes allocatable on the next cycle only. No same-cycle reuse, because in_ready is derived from the registered mask.
- Timeout: each busy tag's age increments per cycle. When age reaches TIMEOUT the tag is freed and a completion is emitted with cpl_timeout=1, cpl_resp=00, cpl_data=0.
- Completion arbitration: at most one completion per cycle.
  - A response beats any timeout.
  - Among simultaneous timeouts, the lowest tag wins; the others retry the next cycle with their age saturated.
  - A response and a timeout for the same tag in the same cycle: the response wins and no timeout is reported.
- outstanding is the registered popcount of the busy mask.
  - It saturates at NUM_TAGS; in_ready=0 while it is full.
  - Allocate and free in the same cycle leave the count unchanged.
- Reset mid-operation: all outstanding state is dropped with no completions. Later responses for old tags raise spurious_err.

Test Plan:
- Reset 100 ns, then 4 accepts of cmd=1, d1=1, d2=2, r1=3 -> req_tag 0,1,2,3 on consecutive cycles; outstanding=4; in_ready=0; req_cmd=0 the cycle after the last request.
- Respond tag 2, resp=01, data=0x3 -> cpl_valid one cycle later with tag=2, cmd=1, resp=01, data=0x3; outstanding=3; the next accept gets tag 2.
- Accept with no response for 64 cycles -> cpl_timeout=1, cpl_resp=00, cpl_data=0, tag freed, outstanding decrements.
- Response on tag 1 with no tags outstanding -> spurious_err=1, held; no cpl_valid.
- Response for tag 0 in the same cycle tag 0's age hits TIMEOUT -> a single completion with resp from out_resp and cpl_timeout=0.
- Assert reset with 3 tags busy -> outputs 0 immediately; after release in_ready=1, outstanding=0, and the first accept gets tag 0.
